// File: rtl/ivector_pkg.sv
// Shared constants and types for the IVector indication path.
package ivector_pkg;
   localparam int IV_NUM_METH = 10;
   localparam int IV_DATA_W   = 32;
   localparam int IV_METH_W   = 32;

   typedef logic [IV_METH_W-1:0] iv_meth_t;
endpackage

// File: rtl/ivector_respond_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after ptr, wrapping at NUM_Q.
module rr_pick #(
   parameter int NUM_Q = 10,
   parameter int PTR_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
   input  logic [NUM_Q-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NUM_Q-1:0] gnt_onehot,
   output logic [PTR_W-1:0] gnt_idx,
   output logic             any
);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_Q - 1);

   logic [PTR_W-1:0]   start;
   logic [2*NUM_Q-1:0] dbl;
   logic [NUM_Q-1:0]   rot;

   always_comb begin
      start      = (ptr >= LAST) ? '0 : ptr + 1'b1;
      dbl        = {req, req};
      rot        = dbl[start +: NUM_Q];
      any        = |req;
      gnt_idx    = '0;
      gnt_onehot = '0;
      // Descending scan so the lowest rotated position wins.
      for (int k = NUM_Q - 1; k >= 0; k--) begin
         if (rot[k]) begin
            if (int'(start) + k >= NUM_Q) gnt_idx = PTR_W'(int'(start) + k - NUM_Q);
            else                          gnt_idx = PTR_W'(int'(start) + k);
         end
      end
      for (int i = 0; i < NUM_Q; i++) begin
         gnt_onehot[i] = any && (gnt_idx == PTR_W'(i));
      end
   end
endmodule

// File: rtl/ivector_respond_sched.sv
// Round-robin drain of per-method response queues onto the single out_heard port,
// through a 1-entry output register that can transfer and reload in the same cycle.
module ivector_respond_sched
   import ivector_pkg::*;
#(
   parameter int NUM_Q  = IV_NUM_METH,
   parameter int DATA_W = IV_DATA_W,
   parameter int METH_W = IV_METH_W
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic [NUM_Q*DATA_W-1:0] q_first,
   input  logic [NUM_Q-1:0]        q_first__RDY,
   input  logic [NUM_Q-1:0]        q_deq__RDY,
   output logic [NUM_Q-1:0]        q_deq__ENA,
   input  logic [NUM_Q-1:0]        cfg_mask,
   output logic                    out_heard__ENA,
   output logic [METH_W-1:0]       out_heard_meth,
   output logic [DATA_W-1:0]       out_heard_v,
   input  logic                    out_heard__RDY,
   output logic [31:0]             stat_grants
);
   localparam int PTR_W = $clog2(NUM_Q);

   logic [NUM_Q-1:0]  eligible;
   logic [NUM_Q-1:0]  gnt_onehot;
   logic [PTR_W-1:0]  gnt_idx;
   logic              gnt_any;
   logic              heard_ena;
   logic              grant;

   logic              out_valid_q, out_valid_d;
   logic [PTR_W-1:0]  out_meth_q,  out_meth_d;
   logic [DATA_W-1:0] out_v_q,     out_v_d;
   logic [PTR_W-1:0]  ptr_q,       ptr_d;
   logic [31:0]       grants_q,    grants_d;

   assign eligible = q_first__RDY & q_deq__RDY & cfg_mask;

   rr_pick #(.NUM_Q(NUM_Q), .PTR_W(PTR_W)) u_pick (
      .req        (eligible),
      .ptr        (ptr_q),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (gnt_any)
   );

   always_comb begin
      heard_ena   = out_valid_q & out_heard__RDY;
      // nRST gating keeps dequeue strobes quiet while reset is asserted.
      grant       = (~out_valid_q | heard_ena) & gnt_any & nRST;
      out_valid_d = out_valid_q;
      out_meth_d  = out_meth_q;
      out_v_d     = out_v_q;
      ptr_d       = ptr_q;
      grants_d    = grants_q;
      if (heard_ena) begin
         out_valid_d = 1'b0;
         grants_d    = grants_q + 32'd1;
      end
      if (grant) begin
         out_valid_d = 1'b1;
         out_meth_d  = gnt_idx;
         out_v_d     = q_first[int'(gnt_idx)*DATA_W +: DATA_W];
         ptr_d       = gnt_idx;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         out_valid_q <= 1'b0;
         out_meth_q  <= '0;
         out_v_q     <= '0;
         ptr_q       <= PTR_W'(NUM_Q - 1);
         grants_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_meth_q  <= out_meth_d;
         out_v_q     <= out_v_d;
         ptr_q       <= ptr_d;
         grants_q    <= grants_d;
      end
   end

   assign q_deq__ENA     = grant ? gnt_onehot : '0;
   assign out_heard__ENA = heard_ena;
   assign out_heard_meth = METH_W'(out_meth_q);
   assign out_heard_v    = out_v_q;
   assign stat_grants    = grants_q;
endmodule

// File: tb/tb_ivector_respond_sched.sv
// Scoreboard bench for ivector_respond_sched: directed tests push expected responses,
// a negedge monitor pops and compares on every out_heard transfer.
module tb_ivector_respond_sched;
   localparam int NUM_Q  = 10;
   localparam int DATA_W = 32;
   localparam int METH_W = 32;
   localparam logic [NUM_Q-1:0] ALL = '1;

   typedef struct {
      logic [METH_W-1:0] m;
      logic [DATA_W-1:0] v;
   } exp_t;

   logic                    CLK = 1'b0;
   logic                    nRST = 1'b0;
   logic [NUM_Q*DATA_W-1:0] q_first;
   logic [NUM_Q-1:0]        qrdy = '0;
   logic [NUM_Q-1:0]        deq;
   logic [NUM_Q-1:0]        mask = '1;
   logic                    ena;
   logic [METH_W-1:0]       meth;
   logic [DATA_W-1:0]       v;
   logic                    rdy = 1'b1;
   logic [31:0]             grants;
   logic                    clr = 1'b0;
   int                      cnt [NUM_Q];

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 CLK = ~CLK;

   ivector_respond_sched #(.NUM_Q(NUM_Q), .DATA_W(DATA_W), .METH_W(METH_W)) dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .q_first        (q_first),
      .q_first__RDY   (qrdy),
      .q_deq__RDY     (qrdy),
      .q_deq__ENA     (deq),
      .cfg_mask       (mask),
      .out_heard__ENA (ena),
      .out_heard_meth (meth),
      .out_heard_v    (v),
      .out_heard__RDY (rdy),
      .stat_grants    (grants)
   );

   // Payload of the k-th item dequeued from queue i: queue 3 starts at 0xA5.
   function automatic logic [31:0] exp_v(int i, int k);
      return 32'(32'hA2 + i) + (32'(k) << 16);
   endfunction

   // Queue model: head advances on each dequeue strobe.
   always @(posedge CLK) begin
      for (int i = 0; i < NUM_Q; i++) cnt[i] <= clr ? 0 : cnt[i] + int'(deq[i]);
   end

   always_comb begin
      q_first = '0;
      for (int i = 0; i < NUM_Q; i++) q_first[i*DATA_W +: DATA_W] = exp_v(i, cnt[i]);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic push(input int m, input int k);
      exp_t e;
      e.m = METH_W'(m);
      e.v = exp_v(m, k);
      sb.push_back(e);
   endtask

   // Monitor: every transfer must match the oldest expected response.
   always @(negedge CLK) begin
      if (ena && !rdy) chk("ena_without_rdy", 1, 0);
      if (ena) begin
         if (sb.size() == 0) chk("unexpected_xfer", {32'(meth), v}, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_meth", 64'(meth), 64'(e.m));
            chk("sb_v", 64'(v), 64'(e.v));
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      qrdy = '0;
      rdy  = 1'b1;
      mask = ALL;
      clr  = 1'b1;
      step();
      step();
      clr  = 1'b0;
      nRST = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   int seq5 [12] = '{0, 1, 3, 4, 5, 6, 7, 8, 9, 0, 1, 3};

   initial begin
      // Reset held with everything eligible
      nRST = 1'b0;
      qrdy = ALL;
      clr  = 1'b1;
      step();
      step();
      @(negedge CLK);
      chk("rst_deq", 64'(deq), 0);
      chk("rst_ena", 64'(ena), 0);
      chk("rst_grants", 64'(grants), 0);
      chk("rst_meth", 64'(meth), 0);
      chk("rst_v", 64'(v), 0);
      do_reset();

      // Single request from queue 3
      qrdy = NUM_Q'(10'h008);
      push(3, 0);
      @(negedge CLK);
      chk("single_deq", 64'(deq), 64'h008);
      chk("single_ena_t", 64'(ena), 0);
      step();
      qrdy = '0;
      @(negedge CLK);
      chk("single_ena_t1", 64'(ena), 1);
      step();
      @(negedge CLK);
      chk("single_grants", 64'(grants), 1);
      chk("single_idle", 64'(ena), 0);

      // Fairness: all queues ready
      do_reset();
      for (int k = 0; k < 12; k++) push(k % 10, k / 10);
      qrdy = ALL;
      for (int k = 0; k < 12; k++) begin
         step();
         if (k == 11) qrdy = '0;
         @(negedge CLK);
         chk("fair_no_idle", 64'(ena), 1);
      end
      step();
      @(negedge CLK);
      chk("fair_grants", 64'(grants), 12);
      chk("fair_drained", 64'(ena), 0);

      // Backpressure with queues 0 and 1
      do_reset();
      rdy  = 1'b0;
      qrdy = NUM_Q'(3);
      push(0, 0);
      push(1, 0);
      @(negedge CLK);
      chk("bp_first_deq", 64'(deq), 1);
      step();
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk("bp_no_deq", 64'(deq), 0);
         chk("bp_no_ena", 64'(ena), 0);
         chk("bp_meth_held", 64'(meth), 0);
         chk("bp_v_held", 64'(v), 64'(exp_v(0, 0)));
         step();
      end
      rdy = 1'b1;
      @(negedge CLK);
      chk("bp_reload_deq", 64'(deq), 2);
      step();
      qrdy = '0;
      @(negedge CLK);
      chk("bp_second_ena", 64'(ena), 1);
      step();
      @(negedge CLK);
      chk("bp_grants", 64'(grants), 2);

      // Mask out queue 2
      do_reset();
      mask = NUM_Q'(10'h3FB);
      for (int k = 0; k < 12; k++) push(seq5[k], (k < 9) ? 0 : 1);
      qrdy = ALL;
      for (int k = 0; k < 12; k++) begin
         step();
         if (k == 11) qrdy = '0;
         @(negedge CLK);
         chk("mask_ena", 64'(ena), 1);
         chk("mask_q2_deq", 64'(deq[2]), 0);
      end
      step();
      mask = '0;
      qrdy = ALL;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         chk("mask_zero_deq", 64'(deq), 0);
         chk("mask_zero_ena", 64'(ena), 0);
         step();
      end
      chk("mask_grants", 64'(grants), 12);

      // Async reset mid-stream, single queue granted every cycle
      do_reset();
      qrdy = NUM_Q'(1);
      push(0, 0);
      push(0, 1);
      push(0, 2);
      for (int k = 0; k < 4; k++) step();
      chk("arst_pre_grants", 64'(grants), 3);
      chk("arst_pre_ena", 64'(ena), 1);
      #1;
      nRST = 1'b0;
      qrdy = '0;
      clr  = 1'b1;
      #1;
      chk("arst_ena_now", 64'(ena), 0);
      chk("arst_grants_now", 64'(grants), 0);
      chk("arst_v_now", 64'(v), 0);
      step();
      clr  = 1'b0;
      qrdy = ALL;
      nRST = 1'b1;
      push(0, 0);
      @(negedge CLK);
      chk("arst_first_deq", 64'(deq), 1);
      step();
      qrdy = '0;
      step();
      @(negedge CLK);
      chk("arst_grants_restart", 64'(grants), 1);

      chk("sb_empty", 64'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
